// File: rtl/timer_pkg.sv
// Shared types, digit limits and BCD digit helpers for the M:SS countdown timer.
package timer_pkg;

  // Timer control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } timer_state_e;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // One BCD digit stepped by cin in either direction.
  // Returns {carry/borrow out, new digit}; dmax is the digit's wrap value.
  function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic [3:0] dmax,
                                          input logic up, input logic cin);
    logic [4:0] r;
    r = {1'b0, d};
    if (cin) begin
      if (up) begin
        if (d >= dmax) r = {1'b1, 4'd0};
        else           r = {1'b0, d + 4'd1};
      end else begin
        if (d == 4'd0) r = {1'b1, dmax};
        else           r = {1'b0, d - 4'd1};
      end
    end
    return r;
  endfunction

  // Clamp an out-of-range digit to its maximum legal value.
  function automatic logic [3:0] bcd_sat(input logic [3:0] d, input logic [3:0] dmax);
    return (d > dmax) ? dmax : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_tick_gen.sv
// Rate divider: one-cycle tick every CLK_DIV cycles spent in RUN.
// The count holds while run is low so a resumed timer keeps its residual phase.
module tick_gen #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next divider count: clear wins, otherwise advance and wrap only while running.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Divider count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD M:SS up/down timer with load, start, pause/resume and terminal detection.
// Handshake: inputs are level-sampled strobes on each clock edge, no ready;
// priority reset > load > pause > start, load is ignored while running.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_DIV    = 50000000,
  parameter int MIN_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*MIN_DIGITS-1:0] load_min,
  input  logic [7:0]              load_sec,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    mode_up,
  output logic [4*MIN_DIGITS-1:0] min_bcd,
  output logic [7:0]              sec_bcd,
  output logic                    running,
  output logic                    expired,
  output logic                    expired_pulse,
  output logic                    tick
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam logic [MW-1:0] MIN_MAX = {MIN_DIGITS{BCD_MAX}};
  localparam logic [7:0]    SEC_MAX = {SEC_TENS_MAX, BCD_MAX};

  timer_state_e  state_q, state_d;
  logic [MW-1:0] min_q, min_d, min_step, min_load;
  logic [7:0]    sec_q, sec_d, sec_step, sec_load;
  logic          mode_up_q, mode_up_d;
  logic          pulse_q, pulse_d;
  logic          cnt_clear, tick_w;
  logic          step_terminal, start_terminal;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == ST_RUN),
    .clear (cnt_clear),
    .tick  (tick_w)
  );

  // Value one second later/earlier: ripple the carry/borrow through all digits.
  always_comb begin
    logic [4:0] r;
    logic       c;
    sec_step = '0;
    min_step = '0;
    c = 1'b1;
    r = bcd_step(sec_q[3:0], BCD_MAX, mode_up_q, c);
    sec_step[3:0] = r[3:0];
    c = r[4];
    r = bcd_step(sec_q[7:4], SEC_TENS_MAX, mode_up_q, c);
    sec_step[7:4] = r[3:0];
    c = r[4];
    for (int i = 0; i < MIN_DIGITS; i++) begin
      r = bcd_step(min_q[4*i +: 4], BCD_MAX, mode_up_q, c);
      min_step[4*i +: 4] = r[3:0];
      c = r[4];
    end
  end

  // Sanitised preset: clamp every digit to its legal range.
  always_comb begin
    min_load = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      min_load[4*i +: 4] = bcd_sat(load_min[4*i +: 4], BCD_MAX);
    end
    sec_load = {bcd_sat(load_sec[7:4], SEC_TENS_MAX), bcd_sat(load_sec[3:0], BCD_MAX)};
  end

  // Step terminal uses the latched direction; start terminal uses the direction being latched.
  assign step_terminal  = mode_up_q ? ((min_step == MIN_MAX) && (sec_step == SEC_MAX))
                                    : ((min_step == '0) && (sec_step == 8'h00));
  assign start_terminal = mode_up ? ((min_q == MIN_MAX) && (sec_q == SEC_MAX))
                                  : ((min_q == '0) && (sec_q == 8'h00));

  // Next-state, digit update, direction latch, divider clear and expiry pulse.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    mode_up_d = mode_up_q;
    pulse_d   = 1'b0;
    cnt_clear = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (tick_w) begin
          min_d = min_step;
          sec_d = sec_step;
          if (step_terminal) begin
            state_d = ST_DONE;
            pulse_d = 1'b1;
          end
        end
        // Reaching the terminal value on the same tick outranks a pause.
        if (pause && !(tick_w && step_terminal)) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (load) begin
          min_d     = min_load;
          sec_d     = sec_load;
          state_d   = ST_IDLE;
          cnt_clear = 1'b1;
        end else if (!pause && start) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (load) begin
          min_d     = min_load;
          sec_d     = sec_load;
          state_d   = ST_IDLE;
          cnt_clear = 1'b1;
        end else if (start) begin
          mode_up_d = mode_up;
          cnt_clear = 1'b1;
          if (start_terminal) begin
            state_d = ST_DONE;
            pulse_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  // State, digit, direction and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      mode_up_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      mode_up_q <= mode_up_d;
      pulse_q   <= pulse_d;
    end
  end

  assign min_bcd       = min_q;
  assign sec_bcd       = sec_q;
  assign running       = (state_q == ST_RUN);
  assign expired       = (state_q == ST_DONE);
  assign expired_pulse = pulse_q;
  assign tick          = tick_w;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus a randomized run
// against a seconds-based reference model.
module tb_bcd_countdown_timer;

  localparam int CLK_DIV = 4;
  localparam int MD      = 2;
  localparam int MAXT    = 99 * 60 + 59;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  // Clock/reset and DUT signals.
  logic       clk = 1'b0;
  logic       reset = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0, mode_up = 1'b0;
  logic [7:0] load_min = 8'h00, load_sec = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, expired, expired_pulse, tick;

  int checks = 0;
  int failures = 0;

  // Reference model: time as plain total seconds.
  int m_state = M_IDLE, m_total = 0, m_div = 0;
  bit m_up = 1'b0, m_pulse = 1'b0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.CLK_DIV(CLK_DIV), .MIN_DIGITS(MD)) dut (
    .clk(clk), .reset(reset), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .pause(pause), .mode_up(mode_up),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .expired(expired),
    .expired_pulse(expired_pulse), .tick(tick)
  );

  function automatic logic [7:0] exp_min(int t);
    int m;
    m = t / 60;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [7:0] exp_sec(int t);
    int s;
    s = t % 60;
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int clamp(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int san_total(logic [7:0] lm, logic [7:0] ls);
    int mins, secs;
    mins = clamp(int'(lm[7:4]), 9) * 10 + clamp(int'(lm[3:0]), 9);
    secs = clamp(int'(ls[7:4]), 5) * 10 + clamp(int'(ls[3:0]), 9);
    return mins * 60 + secs;
  endfunction

  task automatic model_step();
    bit tk, term;
    if (reset) begin
      m_state = M_IDLE; m_total = 0; m_div = 0; m_up = 0; m_pulse = 0;
      return;
    end
    tk = (m_state == M_RUN) && (m_div == CLK_DIV - 1);
    m_pulse = 0;
    term = 0;
    case (m_state)
      M_RUN: begin
        m_div = tk ? 0 : m_div + 1;
        if (tk) begin
          m_total = m_up ? m_total + 1 : m_total - 1;
          term = m_up ? (m_total == MAXT) : (m_total == 0);
          if (term) begin m_state = M_DONE; m_pulse = 1; end
        end
        if (pause && !term) m_state = M_PAUSED;
      end
      M_PAUSED: begin
        if (load) begin
          m_total = san_total(load_min, load_sec); m_state = M_IDLE; m_div = 0;
        end else if (!pause && start) m_state = M_RUN;
      end
      default: begin
        if (load) begin
          m_total = san_total(load_min, load_sec); m_state = M_IDLE; m_div = 0;
        end else if (start) begin
          m_up = mode_up;
          m_div = 0;
          term = m_up ? (m_total == MAXT) : (m_total == 0);
          if (term) begin m_state = M_DONE; m_pulse = 1; end
          else m_state = M_RUN;
        end
      end
    endcase
  endtask

  // Driver tasks: one clock edge with the model following the same inputs.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1; cycle(); reset = 0;
  endtask

  task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
    load_min = lm; load_sec = ls; load = 1; cycle(); load = 0;
  endtask

  task automatic do_start(input logic up);
    mode_up = up; start = 1; cycle(); start = 0;
  endtask

  task automatic test_reset();
    reset = 1; cycle(); cycle(); reset = 0;
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h0000) begin
      failures++; $display("FAIL reset_value got=%h exp=0000", {min_bcd, sec_bcd});
    end
    checks++;
    if ({running, expired, expired_pulse, tick} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {running, expired, expired_pulse, tick});
    end
  endtask

  task automatic test_countdown();
    logic [15:0] e;
    do_reset();
    do_load(8'h01, 8'h01);
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h0101) begin
      failures++; $display("FAIL cd_load got=%h exp=0101", {min_bcd, sec_bcd});
    end
    do_start(0);
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL cd_running got=%b exp=1", running); end
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (k < 3) begin
        checks++;
        if (tick !== 1'b0) begin failures++; $display("FAIL cd_tick_early k=%0d got=%b exp=0", k, tick); end
      end
      if (k == 3) begin
        checks++;
        if (tick !== 1'b1 || {min_bcd, sec_bcd} !== 16'h0101) begin
          failures++; $display("FAIL cd_pre_tick got=%b/%h exp=1/0101", tick, {min_bcd, sec_bcd});
        end
      end
      if (k % 4 == 0) begin
        e = (k == 4) ? 16'h0100 : (k == 8) ? 16'h0059 : 16'h0058;
        checks++;
        if ({min_bcd, sec_bcd} !== e) begin
          failures++; $display("FAIL cd_value k=%0d got=%h exp=%h", k, {min_bcd, sec_bcd}, e);
        end
      end
    end
  endtask

  task automatic test_expire();
    int pulses;
    do_reset();
    do_load(8'h00, 8'h02);
    do_start(0);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      pulses += int'(expired_pulse);
      if (k == 4) begin
        checks++;
        if ({min_bcd, sec_bcd, expired} !== {16'h0001, 1'b0}) begin
          failures++; $display("FAIL exp_first got=%h/%b exp=0001/0", {min_bcd, sec_bcd}, expired);
        end
      end
      if (k == 8) begin
        checks++;
        if ({min_bcd, sec_bcd, expired, expired_pulse, running} !== {16'h0000, 3'b110}) begin
          failures++; $display("FAIL exp_done got=%h/%b%b%b exp=0000/110", {min_bcd, sec_bcd},
                               expired, expired_pulse, running);
        end
      end
      if (k == 9) begin
        checks++;
        if (expired_pulse !== 1'b0 || expired !== 1'b1) begin
          failures++; $display("FAIL exp_pulse_len got=%b/%b exp=0/1", expired_pulse, expired);
        end
      end
    end
    checks++;
    if (pulses != 1 || {min_bcd, sec_bcd} !== 16'h0000) begin
      failures++; $display("FAIL exp_frozen pulses=%0d value=%h exp=1/0000", pulses, {min_bcd, sec_bcd});
    end
  endtask

  task automatic test_zero_start();
    int pulses, ticks;
    do_reset();
    do_load(8'h00, 8'h00);
    do_start(0);
    checks++;
    if ({expired, expired_pulse, running} !== 3'b110 || {min_bcd, sec_bcd} !== 16'h0000) begin
      failures++; $display("FAIL zero_start got=%b%b%b/%h exp=110/0000", expired, expired_pulse,
                           running, {min_bcd, sec_bcd});
    end
    pulses = 0; ticks = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      pulses += int'(expired_pulse);
      ticks += int'(tick);
    end
    checks++;
    if (pulses != 0 || ticks != 0 || expired !== 1'b1) begin
      failures++; $display("FAIL zero_after pulses=%0d ticks=%0d expired=%b exp=0/0/1", pulses, ticks, expired);
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    do_load(8'h05, 8'h30);
    do_start(0);
    cycle();
    pause = 1; cycle(); pause = 0;
    checks++;
    if (running !== 1'b0) begin failures++; $display("FAIL pr_paused got=%b exp=0", running); end
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h0530 || tick !== 1'b0) begin
        failures++; $display("FAIL pr_hold k=%0d got=%h/%b exp=0530/0", k, {min_bcd, sec_bcd}, tick);
      end
    end
    do_start(0);
    cycle();
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h0530) begin
      failures++; $display("FAIL pr_resume1 got=%h exp=0530", {min_bcd, sec_bcd});
    end
    cycle();
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h0529) begin
      failures++; $display("FAIL pr_resume2 got=%h exp=0529", {min_bcd, sec_bcd});
    end
  endtask

  task automatic test_count_up();
    do_reset();
    do_load(8'h98, 8'h59);
    do_start(1);
    mode_up = 0;
    repeat (4) cycle();
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h9900 || running !== 1'b1) begin
      failures++; $display("FAIL up_first got=%h/%b exp=9900/1", {min_bcd, sec_bcd}, running);
    end
    pause = 1; cycle(); pause = 0;
    do_load(8'h99, 8'h58);
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h9958 || expired !== 1'b0) begin
      failures++; $display("FAIL up_reload got=%h/%b exp=9958/0", {min_bcd, sec_bcd}, expired);
    end
    do_start(1);
    mode_up = 0;
    repeat (4) cycle();
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h9959 || {expired, expired_pulse} !== 2'b11) begin
      failures++; $display("FAIL up_max got=%h/%b%b exp=9959/11", {min_bcd, sec_bcd}, expired, expired_pulse);
    end
  endtask

  task automatic test_sanitise_and_ignore();
    do_reset();
    do_load(8'hA3, 8'h7C);
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h9359) begin
      failures++; $display("FAIL san_value got=%h exp=9359", {min_bcd, sec_bcd});
    end
    do_start(0);
    do_load(8'h01, 8'h00);
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h9359 || running !== 1'b1) begin
      failures++; $display("FAIL run_load_ignored got=%h/%b exp=9359/1", {min_bcd, sec_bcd}, running);
    end
    reset = 1; cycle();
    checks++;
    if ({min_bcd, sec_bcd, running, expired, expired_pulse, tick} !== 20'h0) begin
      failures++; $display("FAIL reset_mid_run got=%h exp=00000", {min_bcd, sec_bcd, running, expired, expired_pulse, tick});
    end
    reset = 0;
  endtask

  task automatic test_random();
    logic [19:0] exp_v;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      reset   = ($urandom_range(0, 299) == 0);
      load    = ($urandom_range(0, 19) == 0);
      start   = ($urandom_range(0, 7) == 0);
      pause   = ($urandom_range(0, 15) == 0);
      mode_up = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: begin load_min = 8'h00; load_sec = 8'($urandom_range(0, 6)); end
        1: begin load_min = 8'h99; load_sec = {4'h5, 4'($urandom_range(5, 9))}; end
        default: begin load_min = 8'($urandom); load_sec = 8'($urandom); end
      endcase
      cycle();
      exp_v = {exp_min(m_total), exp_sec(m_total), m_state == M_RUN, m_state == M_DONE, m_pulse,
               (m_state == M_RUN) && (m_div == CLK_DIV - 1)};
      checks++;
      if ({min_bcd, sec_bcd, running, expired, expired_pulse, tick} !== exp_v) begin
        failures++; $display("FAIL rand n=%0d got=%h exp=%h", n,
                             {min_bcd, sec_bcd, running, expired, expired_pulse, tick}, exp_v);
      end
    end
    reset = 0; load = 0; start = 0; pause = 0; mode_up = 0;
  endtask

  // Scenario sequence and final report.
  initial begin
    test_reset();
    test_countdown();
    test_expire();
    test_zero_start();
    test_pause_resume();
    test_count_up();
    test_sanitise_and_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised successor to the game's M:SS countdown counter and its companion rate divider.
- Holds a BCD time value of MIN_DIGITS minute digits plus two second digits.
- Counts down (or up) once per internally generated tick, with load, start, pause/resume and terminal detection.
- Outputs drive the 7-segment decoders and the game-over logic directly.

Parameters:
- CLK_DIV, 50000000, clk cycles per count tick (>=2).
- MIN_DIGITS, 2, number of BCD minute digits (1..3).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  load preset value (accepted only when not RUN)
- load_min  in  4*MIN_DIGITS  preset minutes, BCD, LS digit at [3:0]
- load_sec  in  8  preset seconds, BCD, tens at [7:4]
- start  in  1  start or resume counting
- pause  in  1  pause counting
- mode_up  in  1  0=count down, 1=count up; latched on accepted start from IDLE/DONE
- min_bcd  out  4*MIN_DIGITS  current minutes
- sec_bcd  out  8  current seconds
- running  out  1  high in RUN
- expired  out  1  level, high in DONE
- expired_pulse  out  1  one-cycle pulse on entry to DONE
- tick  out  1  one-cycle tick strobe, for display blink

Behaviour:
- Reset: all digits 0, state IDLE, running=0, expired=0, expired_pulse=0, tick=0, divider count=0, latched mode=down.
- Tick generator: counter runs 0..CLK_DIV-1 only in RUN; tick=1 for the single cycle the counter equals CLK_DIV-1, then it wraps to 0. Counter clears on reset, load and start-from-IDLE/DONE, and holds in PAUSED.
- States:
  - IDLE -start-> RUN.
  - RUN -pause-> PAUSED.
  - RUN -terminal reached-> DONE.
  - PAUSED -start-> RUN (resumes the residual divider count).
  - DONE -start-> RUN (from the current digits).
  - load in IDLE/PAUSED/DONE -> IDLE.
- Priority: reset > load > pause > start. load in RUN is ignored. start and pause together in RUN or PAUSED -> PAUSED.
- Load sanitising:
  - Any digit >9 saturates to 9.
  - Seconds tens >5 saturates to 5.
  - Load clears expired.
- Down count on tick: the value decrements by one second.
  - sec ones 0->9 borrows; sec tens 0->5 borrows.
  - Each minute digit 0->9 borrows to the next digit.
  - If the new value is all-zero, go to DONE in the same update.
- Up count on tick: the value increments by one second.
  - sec ones 9->0 carries; sec tens 5->0 carries.
  - Each minute digit 9->0 carries.
  - If the new value is the maximum (all minute digits 9, seconds 59), go to DONE.
- Terminal at start: start in down mode with value 00:00, or in up mode with value at maximum, goes straight to DONE next cycle with expired_pulse. Digits are unchanged and no tick is generated.
- DONE: digits frozen; further ticks ignored; expired_pulse fires only once per entry.
- Latency: start accepted at edge N -> running=1 after N. The first digit change is visible after edge N+CLK_DIV; subsequent changes every CLK_DIV cycles.
- Pause/resume timing: a pause after k divider cycles followed by resume gives the next update after CLK_DIV-k further RUN cycles.
- Outputs are all registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package timer_pkg:
  - State encoding typedef (IDLE, RUN, PAUSED, DONE).
  - Constants BCD_MAX=4'd9 and SEC_TENS_MAX=4'd5.
  - Helper function for single-digit BCD decrement/increment with borrow/carry.
- One sub-module: tick_gen (parameter CLK_DIV; ports clk, reset, run, clear, tick). It replaces the ad hoc rate divider used so far.

Test Plan (CLK_DIV=4, MIN_DIGITS=2):
- Load 01:01, start, run 12 cycles -> values 01:00, 00:59, 00:58 appear at 4-cycle spacing starting exactly 4 cycles after start.
- Load 00:02, start -> 00:01, then 00:00 with expired=1 and expired_pulse high for exactly one cycle; later ticks leave 00:00.
- Load 00:00, start -> DONE next cycle, expired_pulse once, digits unchanged.
- Load 05:30, start, pause after 2 cycles, hold 10 cycles, start -> value stays 05:30 while paused; 05:29 after 2 further RUN cycles.
- Load 98:59, mode_up=1, start -> 99:00 on first tick; then load 99:58, start -> 99:59 with expired=1.
- load_sec=8'h7C, load_min=8'hA3 -> sec_bcd=8'h59, min_bcd=8'h93. A load during RUN is ignored. Reset mid-RUN -> next cycle all outputs 0, state IDLE.
